spi_slave_eth: RTL and testbench

SPI responder (slave) byte engine, the far end of the team's SPI master byte engine. Mode 0: CPOL=0, sample on rising SCLK, shift on falling SCLK, MSB first, CS active-low. All SPI pins are oversampled in the single system clock domain. Multi-byte frames are delimited by CS; each received byte is handed to the user side and the next transmit byte is requested.

---
 rtl/spi_eth_pkg.sv | 23 ++
 rtl/spi_in_sync.sv | 32 +++
 rtl/spi_slave_eth.sv | 191 +++++++++++++++++++
 tb/tb_spi_slave_eth.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_eth_pkg.sv
// Shared definitions for the SPI responder byte engine: FSM encoding,
// frame geometry and SPI mode constants.
package spi_eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } spi_state_t;

  localparam int unsigned SPI_BITS = 8;

  // Mode 0 only: clock idles low, sample on rising edge, shift on falling edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam logic [3:0] BIT_CNT_FULL = 4'(SPI_BITS);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one SPI pin plus a history flop that turns
// the synchronized level into single-clock rise/fall strobes.
module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = o_level & ~r_hist;
  assign o_fall  = ~o_level & r_hist;

endmodule

// File: rtl/spi_slave_eth.sv
// SPI mode-0 responder byte engine: oversamples CS/SCLK/MOSI in clk, hands
// each received byte to the user side and requests the next transmit byte.
//
// state  | meaning
// IDLE   | CS inactive, waiting for CS fall
// ACTIVE | frame in progress, shifting bits on SCLK edges
// DONE   | one clk after CS rise: frame_done/abort pulse, outputs idled
module spi_slave_eth
  import spi_eth_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_spi_cs,
  input  logic       i_spi_dclk,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso,
  output logic       o_miso_oe,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_req,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic [7:0] o_byte_cnt,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_abort
);

  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_dclk_lvl, w_dclk_rise, w_dclk_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (i_spi_cs),
    .o_level (w_cs_lvl),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dclk (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (i_spi_dclk),
    .o_level (w_dclk_lvl),
    .o_rise  (w_dclk_rise),
    .o_fall  (w_dclk_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (i_spi_mosi),
    .o_level (w_mosi),
    .o_rise  (w_mosi_rise),
    .o_fall  (w_mosi_fall)
  );

  spi_state_t r_state, w_next;
  logic       w_start, w_end, w_act, w_byte_full;

  logic [7:0] r_tx_shift;
  logic [7:0] r_rx_shift;
  logic [3:0] r_bit_cnt;
  logic       r_load_pending;
  logic       r_miso, r_oe, r_tx_req, r_rx_valid, r_busy, r_frame_done, r_abort;
  logic [7:0] r_rx_data, r_byte_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_end   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_next  = ST_ACTIVE;
          w_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_cs_rise) begin
          w_next = ST_DONE;
          w_end  = 1'b1;
        end
      end
      ST_DONE: begin
        // A new CS fall arriving while we tidy up starts the next frame directly.
        if (w_cs_fall) begin
          w_next  = ST_ACTIVE;
          w_start = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // CS level high also blocks SCLK edges in the CS-rise clk, giving CS priority.
  assign w_act       = (r_state == ST_ACTIVE) && !w_cs_lvl;
  assign w_byte_full = (r_state == ST_ACTIVE) && (r_bit_cnt == BIT_CNT_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shift     <= '0;
      r_rx_shift     <= '0;
      r_bit_cnt      <= '0;
      r_load_pending <= 1'b0;
      r_miso         <= IDLE_MISO;
      r_oe           <= 1'b0;
      r_tx_req       <= 1'b0;
      r_rx_valid     <= 1'b0;
      r_rx_data      <= '0;
      r_byte_cnt     <= '0;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
      r_abort        <= 1'b0;
    end else begin
      r_tx_req     <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_frame_done <= 1'b0;
      r_abort      <= 1'b0;

      // Commit one clk after the 8th rise; a byte completed just before CS rise still counts.
      if (w_byte_full) begin
        r_rx_data      <= r_rx_shift;
        r_rx_valid     <= 1'b1;
        r_byte_cnt     <= sat_inc8(r_byte_cnt);
        r_bit_cnt      <= '0;
        r_load_pending <= 1'b1;
      end

      if (w_start) begin
        r_tx_shift     <= i_tx_data;
        r_miso         <= i_tx_data[7];
        r_tx_req       <= 1'b1;
        r_rx_shift     <= '0;
        r_bit_cnt      <= '0;
        r_byte_cnt     <= '0;
        r_busy         <= 1'b1;
        r_oe           <= 1'b1;
        r_load_pending <= 1'b0;
      end else if (w_end) begin
        r_frame_done   <= 1'b1;
        r_abort        <= (r_bit_cnt != 4'd0) && (r_bit_cnt != BIT_CNT_FULL);
        r_busy         <= 1'b0;
        r_oe           <= 1'b0;
        r_miso         <= IDLE_MISO;
        r_load_pending <= 1'b0;
      end else if (w_act) begin
        if (w_dclk_rise) begin
          r_rx_shift <= {r_rx_shift[6:0], w_mosi};
          r_bit_cnt  <= r_bit_cnt + 4'd1;
        end else if (w_dclk_fall) begin
          if (r_load_pending) begin
            r_tx_shift     <= i_tx_data;
            r_miso         <= i_tx_data[7];
            r_tx_req       <= 1'b1;
            r_load_pending <= 1'b0;
          end else if (r_bit_cnt != 4'd0) begin
            // Falls before a byte's first rise are ignored so the MSB is never skipped.
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            r_miso     <= r_tx_shift[6];
          end
        end
      end
    end
  end

  logic w_unused;
  assign w_unused = &{1'b0, w_dclk_lvl, w_mosi_rise, w_mosi_fall, r_tx_shift[7]};

  assign o_spi_miso   = r_miso;
  assign o_miso_oe    = r_oe;
  assign o_tx_req     = r_tx_req;
  assign o_rx_valid   = r_rx_valid;
  assign o_rx_data    = r_rx_data;
  assign o_byte_cnt   = r_byte_cnt;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_abort      = r_abort;

endmodule

// File: tb/tb_spi_slave_eth.sv
// Bench for spi_slave_eth: a behavioural SPI master drives two instances
// (SYNC_STAGES=2/IDLE_MISO=0 and SYNC_STAGES=3/IDLE_MISO=1) and checks them.
module tb_spi_slave_eth;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic cs = 1'b1, dclk = 1'b0, mosi = 1'b0;
  logic [7:0] tx_a = 8'h00, tx_b = 8'h00;

  logic miso_a, oe_a, txreq_a, rxv_a, busy_a, fd_a, abort_a;
  logic [7:0] rxd_a, cnt_a;
  logic miso_b, oe_b, txreq_b, rxv_b, busy_b, fd_b, abort_b;
  logic [7:0] rxd_b, cnt_b;

  spi_slave_eth #(.SYNC_STAGES(2), .IDLE_MISO(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_spi_cs(cs), .i_spi_dclk(dclk), .i_spi_mosi(mosi),
    .o_spi_miso(miso_a), .o_miso_oe(oe_a), .i_tx_data(tx_a), .o_tx_req(txreq_a),
    .o_rx_valid(rxv_a), .o_rx_data(rxd_a), .o_byte_cnt(cnt_a), .o_busy(busy_a),
    .o_frame_done(fd_a), .o_abort(abort_a)
  );

  spi_slave_eth #(.SYNC_STAGES(3), .IDLE_MISO(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_spi_cs(cs), .i_spi_dclk(dclk), .i_spi_mosi(mosi),
    .o_spi_miso(miso_b), .o_miso_oe(oe_b), .i_tx_data(tx_b), .o_tx_req(txreq_b),
    .o_rx_valid(rxv_b), .o_rx_data(rxd_b), .o_byte_cnt(cnt_b), .o_busy(busy_b),
    .o_frame_done(fd_b), .o_abort(abort_b)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] tx_seq [0:599];
  int idx_a, idx_b;
  logic [7:0] rxq_a [$];
  logic [7:0] rxq_b [$];
  int req_a, req_b, fdc_a, fdc_b, abp_a, abp_b;

  logic [7:0] m_tx [0:15];
  logic [7:0] mr_a [0:15];
  logic [7:0] mr_b [0:15];
  logic       busy_mid_a;
  logic [7:0] cnt_mid_a;

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] tx;
    int         nbits;
    int         exp_nrx;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
    int         exp_abort;
    logic [7:0] exp_cnt;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // User side: every tx request is answered with the next entry of tx_seq.
  initial begin
    forever begin
      @(negedge clk);
      if (rxv_a) rxq_a.push_back(rxd_a);
      if (rxv_b) rxq_b.push_back(rxd_b);
      if (txreq_a) begin
        req_a++;
        if (idx_a < 599) idx_a++;
        tx_a = tx_seq[idx_a];
      end
      if (txreq_b) begin
        req_b++;
        if (idx_b < 599) idx_b++;
        tx_b = tx_seq[idx_b];
      end
      if (fd_a) fdc_a++;
      if (fd_b) fdc_b++;
      if (abort_a) abp_a++;
      if (abort_b) abp_b++;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    rxq_a.delete();
    rxq_b.delete();
    req_a = 0; req_b = 0; fdc_a = 0; fdc_b = 0; abp_a = 0; abp_b = 0;
  endtask

  task automatic set_tx();
    idx_a = 0;
    idx_b = 0;
    tx_a = tx_seq[0];
    tx_b = tx_seq[0];
  endtask

  // Mode-0 master: data set while SCLK low, both slaves' MISO read at each rise.
  task automatic xfer(input int nbits, input int h, input bit keep_cs, input int gap);
    logic [7:0] mi_a, mi_b;
    mi_a = 8'h00;
    mi_b = 8'h00;
    @(negedge clk);
    cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = m_tx[i/8][7 - (i % 8)];
      repeat (h) @(negedge clk);
      if (i == 0) begin
        busy_mid_a = busy_a & oe_a;
        cnt_mid_a  = cnt_a;
      end
      if ((i % 8) == 0) begin
        mi_a = 8'h00;
        mi_b = 8'h00;
      end
      mi_a = {mi_a[6:0], miso_a};
      mi_b = {mi_b[6:0], miso_b};
      mr_a[i/8] = mi_a;
      mr_b[i/8] = mi_b;
      dclk = 1'b1;
      repeat (h) @(negedge clk);
      dclk = 1'b0;
    end
    if (!keep_cs) begin
      repeat (h) @(negedge clk);
      cs = 1'b1;
      repeat (gap) @(negedge clk);
    end
  endtask

  function automatic logic [22:0] pack_a();
    return {miso_a, oe_a, txreq_a, rxv_a, rxd_a, cnt_a, busy_a, fd_a, abort_a};
  endfunction

  function automatic logic [22:0] pack_b();
    return {miso_b, oe_b, txreq_b, rxv_b, rxd_b, cnt_b, busy_b, fd_b, abort_b};
  endfunction

  initial begin
    logic [7:0] got;
    int model, total, n;

    vt[0] = '{8'hA5, 8'h3C, 8, 1, 8'hA5, 8'h3C, 0, 8'd1};
    vt[1] = '{8'h00, 8'hFF, 8, 1, 8'h00, 8'hFF, 0, 8'd1};
    vt[2] = '{8'hFF, 8'h00, 8, 1, 8'hFF, 8'h00, 0, 8'd1};
    vt[3] = '{8'h81, 8'h7E, 8, 1, 8'h81, 8'h7E, 0, 8'd1};
    vt[4] = '{8'hF0, 8'hB7, 5, 0, 8'h00, 8'h16, 1, 8'd0};
    vt[5] = '{8'h3C, 8'hC3, 1, 0, 8'h00, 8'h01, 1, 8'd0};
    vt[6] = '{8'h5A, 8'hA5, 7, 0, 8'h00, 8'h52, 1, 8'd0};

    for (int i = 0; i < 600; i++) tx_seq[i] = 8'h00;
    clear_mon();
    set_tx();

    repeat (3) @(negedge clk);
    chk("reset_a", 32'(pack_a()), 32'h0);
    chk("reset_b", 32'(pack_b()), 32'h400000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vt[k]) begin
      clear_mon();
      tx_seq[0] = vt[k].tx;
      tx_seq[1] = 8'h00;
      tx_seq[2] = 8'h00;
      set_tx();
      m_tx[0] = vt[k].mosi;
      xfer(vt[k].nbits, 4, 1'b0, 8);
      chk($sformatf("vec%0d_nrx", k), 32'(rxq_a.size()), 32'(vt[k].exp_nrx));
      if (vt[k].exp_nrx > 0) begin
        got = (rxq_a.size() > 0) ? rxq_a.pop_front() : 8'hxx;
        chk($sformatf("vec%0d_rx", k), 32'(got), 32'(vt[k].exp_rx));
      end
      chk($sformatf("vec%0d_miso", k), 32'(mr_a[0]), 32'(vt[k].exp_miso));
      chk($sformatf("vec%0d_frame_done", k), 32'(fdc_a), 32'd1);
      chk($sformatf("vec%0d_abort", k), 32'(abp_a), 32'(vt[k].exp_abort));
      chk($sformatf("vec%0d_byte_cnt", k), 32'(cnt_a), 32'(vt[k].exp_cnt));
      chk($sformatf("vec%0d_tx_req", k), 32'(req_a), 32'(1 + vt[k].nbits / 8));
      chk($sformatf("vec%0d_busy_mid", k), 32'(busy_mid_a), 32'd1);
      chk($sformatf("vec%0d_idle", k), 32'({busy_a, oe_a, miso_a}), 32'd0);
    end

    // Three-byte frame; user answers each request with the next response byte.
    clear_mon();
    tx_seq[0] = 8'h3C; tx_seq[1] = 8'hC1; tx_seq[2] = 8'hC2; tx_seq[3] = 8'hC3; tx_seq[4] = 8'h00;
    set_tx();
    m_tx[0] = 8'h11; m_tx[1] = 8'h22; m_tx[2] = 8'h33;
    xfer(24, 4, 1'b0, 8);
    chk("three_nrx", 32'(rxq_a.size()), 32'd3);
    for (int j = 0; j < 3; j++) begin
      got = (rxq_a.size() > 0) ? rxq_a.pop_front() : 8'hxx;
      chk($sformatf("three_rx%0d", j), 32'(got), 32'(m_tx[j]));
      chk($sformatf("three_miso%0d", j), 32'(mr_a[j]), 32'(tx_seq[j]));
    end
    chk("three_byte_cnt", 32'(cnt_a), 32'd3);
    chk("three_tx_req", 32'(req_a), 32'd4);
    chk("three_abort", 32'(abp_a), 32'd0);

    // Back-to-back frames with CS high for 3 clk in between.
    clear_mon();
    tx_seq[0] = 8'hD0; tx_seq[1] = 8'hD1; tx_seq[2] = 8'hD2; tx_seq[3] = 8'hD3; tx_seq[4] = 8'hD4;
    set_tx();
    m_tx[0] = 8'h71; m_tx[1] = 8'h72;
    xfer(16, 4, 1'b0, 2);
    m_tx[0] = 8'h73;
    xfer(8, 4, 1'b0, 8);
    chk("b2b_cnt_restart", 32'(cnt_mid_a), 32'd0);
    chk("b2b_miso", 32'(mr_a[0]), 32'hD3);
    chk("b2b_nrx", 32'(rxq_a.size()), 32'd3);
    for (int j = 0; j < 3; j++) begin
      got = (rxq_a.size() > 0) ? rxq_a.pop_front() : 8'hxx;
      chk($sformatf("b2b_rx%0d", j), 32'(got), 32'(8'h71 + 8'(j)));
    end
    chk("b2b_frame_done", 32'(fdc_a), 32'd2);
    chk("b2b_byte_cnt", 32'(cnt_a), 32'd1);
    chk("b2b_tx_req", 32'(req_a), 32'd5);

    // Reset 2 clk after the 4th bit of a byte, then a clean new frame.
    clear_mon();
    tx_seq[0] = 8'hE7; tx_seq[1] = 8'h00;
    set_tx();
    m_tx[0] = 8'hFF;
    xfer(4, 4, 1'b1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_a", 32'(pack_a()), 32'h0);
    chk("rst_mid_b", 32'(pack_b()), 32'h400000);
    @(negedge clk);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_no_resume", 32'(fdc_a + abp_a), 32'd0);
    clear_mon();
    tx_seq[0] = 8'h96; tx_seq[1] = 8'h00;
    set_tx();
    m_tx[0] = 8'h5A;
    xfer(8, 4, 1'b0, 8);
    got = (rxq_a.size() > 0) ? rxq_a.pop_front() : 8'hxx;
    chk("rst_next_rx", 32'(got), 32'h5A);
    chk("rst_next_miso", 32'(mr_a[0]), 32'h96);
    chk("rst_next_cnt", 32'(cnt_a), 32'd1);
    chk("rst_next_abort", 32'(abp_a), 32'd0);

    // Random frames at half-period 5: the minimum for SYNC_STAGES=3.
    for (int i = 0; i < 600; i++) tx_seq[i] = 8'($urandom);
    clear_mon();
    set_tx();
    model = 0;
    total = 0;
    while (total < 256) begin
      n = int'($urandom_range(1, 8));
      if (n > 256 - total) n = 256 - total;
      for (int j = 0; j < n; j++) m_tx[j] = 8'($urandom);
      xfer(n * 8, 5, 1'b0, 6);
      chk("rand_nrx_a", 32'(rxq_a.size()), 32'(n));
      chk("rand_nrx_b", 32'(rxq_b.size()), 32'(n));
      for (int j = 0; j < n; j++) begin
        got = (rxq_a.size() > 0) ? rxq_a.pop_front() : 8'hxx;
        chk("rand_rx_a", 32'(got), 32'(m_tx[j]));
        got = (rxq_b.size() > 0) ? rxq_b.pop_front() : 8'hxx;
        chk("rand_rx_b", 32'(got), 32'(m_tx[j]));
        chk("rand_miso_a", 32'(mr_a[j]), 32'(tx_seq[model + j]));
        chk("rand_miso_b", 32'(mr_b[j]), 32'(tx_seq[model + j]));
      end
      chk("rand_cnt_b", 32'(cnt_b), 32'(n));
      chk("rand_idle_b", 32'({busy_b, oe_b, miso_b}), 32'd1);
      model += n + 1;
      total += n;
    end
    chk("rand_abort_b", 32'(abp_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
